// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary.
// Optional macro IFID_PREDECODE_EN adds a predecoded control-flow bit to each packet.
package pipe_pkg;

  localparam int XLEN = 32;
  // addi x0,x0,0: what decode sees while nothing is buffered
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
`ifdef IFID_PREDECODE_EN
    logic            ctrl;
`endif
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Queue state is implied by the entry count; this names it for debug
  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode bundle for if_id_queue.
// Optional macro IFID_PREDECODE_EN adds id_is_ctrl.
//
// Handshake: a transfer on either side happens at a rising edge where the
// producer's valid and the consumer's ready are both high. if_ready depends
// only on registered state (no pass-through), id_* are registered outputs,
// and a valid side never depends on its own ready.
interface if_id_queue_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = pipe_pkg::XLEN
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                 if_valid;
  logic [XLEN-1:0]      if_instr;
  logic [XLEN-1:0]      if_pc;
  logic                 if_ready;
  logic                 id_valid;
  logic [XLEN-1:0]      id_instr;
  logic [XLEN-1:0]      id_pc;
  logic                 id_ready;
  logic [OCC_W-1:0]     occupancy;
  pipe_pkg::q_state_t   dbg_state;
`ifdef IFID_PREDECODE_EN
  logic                 id_is_ctrl;
`endif

  // The queue itself
  modport slave (
    input  if_valid, if_instr, if_pc, id_ready,
    output if_ready, id_valid, id_instr, id_pc, occupancy, dbg_state
`ifdef IFID_PREDECODE_EN
    , output id_is_ctrl
`endif
  );

  // Fetch and decode stages surrounding the queue
  modport master (
    output if_valid, if_instr, if_pc, id_ready,
    input  if_ready, id_valid, id_instr, id_pc, occupancy, dbg_state
`ifdef IFID_PREDECODE_EN
    , input id_is_ctrl
`endif
  );

endinterface

// File: rtl/if_id_queue_predecode.sv
// Opcode classifier: flags branches, JAL and JALR so decode can react early.
// Only instantiated when IFID_PREDECODE_EN is defined.
module ifid_predecode
  import pipe_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_ctrl
);

  // Control-flow opcodes redirect fetch; everything else is straight-line
  always_comb begin
    is_ctrl = 1'b0;
    case (opcode)
      OP_BRANCH, OP_JAL, OP_JALR: is_ctrl = 1'b1;
      default:                    is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: small circular buffer of {instr, pc} between
// fetch and decode. Flush empties it for a taken branch/jump.
// Optional macro IFID_PREDECODE_EN stores a predecoded control-flow bit per
// entry and presents it on id_is_ctrl.
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
module if_id_queue #(
  parameter int              DEPTH     = 2,
  parameter int              XLEN      = pipe_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  if_id_queue_if.slave  q
);
  import pipe_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_pkt_t       mem_q [DEPTH];
  fetch_pkt_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fetch_pkt_t wr_pkt;
  fetch_pkt_t head;
  logic       empty;
  logic       push;
  logic       pop;

  assign empty      = (count_q == '0);
  // Ready comes from registered count only: a full queue never accepts,
  // even when decode drains an entry in the same cycle.
  assign q.if_ready = (count_q != FULL_CNT);
  assign q.id_valid = !empty;
  assign push       = q.if_valid && q.if_ready && !flush;
  assign pop        = q.id_valid && q.id_ready && !flush;
  assign q.occupancy = count_q;

`ifdef IFID_PREDECODE_EN
  logic push_is_ctrl;

  ifid_predecode u_predecode (
    .opcode  (q.if_instr[6:0]),
    .is_ctrl (push_is_ctrl)
  );
`endif

  // Pack the incoming fetch into a storage entry
  always_comb begin
    wr_pkt       = '0;
    wr_pkt.instr = q.if_instr;
    wr_pkt.pc    = q.if_pc;
`ifdef IFID_PREDECODE_EN
    wr_pkt.ctrl  = push_is_ctrl;
`endif
  end

  // Next-state: flush wins over handshakes; otherwise advance on push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_pkt;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head presentation, masked to a NOP bubble while empty
  always_comb begin
    head       = mem_q[rd_ptr_q];
    q.id_instr = empty ? NOP_INSTR : head.instr;
    q.id_pc    = empty ? '0 : head.pc;
`ifdef IFID_PREDECODE_EN
    q.id_is_ctrl = empty ? 1'b0 : head.ctrl;
`endif
    if (empty)                  q.dbg_state = Q_EMPTY;
    else if (count_q == FULL_CNT) q.dbg_state = Q_FULL;
    else                        q.dbg_state = Q_PARTIAL;
  end

  // Pointer/count registers; reset overrides flush and handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: no reset needed, outputs are masked while empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed testbench for if_id_queue with an expected-entry scoreboard.
// Build with IFID_PREDECODE_EN defined to also check id_is_ctrl.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  if_id_queue_if #(.DEPTH(DEPTH)) q ();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (q.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];   // {ctrl, instr, pc}
  logic        cur_ctrl = 1'b0;
  logic        chk_en = 1'b0;
  int          size_seen = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ctrl, input logic rdy, input logic fl, input logic rst);
    @(posedge clk);
    #2;
    q.if_valid = v;
    q.if_instr = instr;
    q.if_pc    = pc;
    cur_ctrl   = ctrl;
    q.id_ready = rdy;
    flush      = fl;
    reset      = rst;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  // ---------------- expected-side model: entries accepted at each edge ----------------
  always @(posedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else if (q.if_valid && size_seen != DEPTH) begin
      exp_q.push_back({cur_ctrl, q.if_instr, q.if_pc});
    end
  end

  // ---------------- monitor: compare head, pop on consumption ----------------
  logic [64:0] head;
  int          sz;
  always @(negedge clk) begin
    if (chk_en) begin
      sz = exp_q.size();
      size_seen = sz;
      check("occupancy", 64'(q.occupancy), 64'(sz));
      check("if_ready", 64'(q.if_ready), 64'(sz != DEPTH));
      check("id_valid", 64'(q.id_valid), 64'(sz != 0));
      check("dbg_state", 64'(q.dbg_state),
            64'((sz == 0) ? pipe_pkg::Q_EMPTY : (sz == DEPTH) ? pipe_pkg::Q_FULL : pipe_pkg::Q_PARTIAL));
      if (sz != 0) begin
        head = exp_q[0];
        check("id_instr", 64'(q.id_instr), 64'(head[63:32]));
        check("id_pc", 64'(q.id_pc), 64'(head[31:0]));
`ifdef IFID_PREDECODE_EN
        check("id_is_ctrl", 64'(q.id_is_ctrl), 64'(head[64]));
`endif
        if (q.id_ready) void'(exp_q.pop_front());
      end else begin
        check("id_instr_empty", 64'(q.id_instr), 64'(NOP));
        check("id_pc_empty", 64'(q.id_pc), 64'h0);
`ifdef IFID_PREDECODE_EN
        check("id_is_ctrl_empty", 64'(q.id_is_ctrl), 64'h0);
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    q.if_valid = 1'b0;
    q.if_instr = 32'h0;
    q.if_pc    = 32'h0;
    q.id_ready = 1'b0;

    // reset for two edges, then idle: empty-state outputs
    @(posedge clk);
    @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;
    idle(1'b0);
    idle(1'b0);

    // single instruction with decode ready: one-cycle latency, then empty
    drive(1'b1, 32'h00500093, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // back-pressure: fill while decode stalls, fetch holds pc 8 until accepted
    drive(1'b1, 32'h00100093, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200093, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00300093, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);  // full: pop only
    drive(1'b1, 32'h00300093, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);  // pc 8 accepted
    idle(1'b1);
    idle(1'b1);

    // full queue flushed while fetch pushes and decode pops
    drive(1'b1, 32'h00a00093, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00b00093, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00c00093, 32'h48, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    drive(1'b1, 32'h00d00093, 32'h4c, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // streaming: push and pop every cycle, pointers wrap several times
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h00000093 | (32'(i) << 20), 32'(i * 4), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    // reset mid-stream beats flush and handshakes
    drive(1'b1, 32'h00e00093, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h00f00093, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h01000093, 32'h88, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b0);

    // opcode mix: beq, addi, jal, jalr, add
    drive(1'b1, 32'h00000063, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00000013, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000006f, 32'h108, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00000067, 32'h10c, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h00000033, 32'h110, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling queue between the instruction-fetch stage and the decode stage of the 5-stage RV32I pipeline.
- Captures each fetched instruction together with its PC into a small circular buffer.
- Presents the oldest entry to decode under a valid/ready handshake.
- Back-pressure is fed to fetch: fetch's stall equals !if_ready. A taken branch or jump flushes every buffered entry.

Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2.
- XLEN, 32, width of instruction and PC.
- NOP_INSTR, 32'h00000013, instruction presented while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- flush  in  1  discard all entries (taken branch/jump resolved downstream).
- if_valid  in  1  fetch presents a valid instruction this cycle.
- if_instr  in  XLEN  fetched instruction.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_ready  out  1  queue can accept this cycle; fetch drives stall = !if_ready.
- id_valid  out  1  head entry is valid.
- id_instr  out  XLEN  head instruction; NOP_INSTR when empty.
- id_pc  out  XLEN  head PC; 0 when empty.
- id_ready  in  1  decode consumes the head this cycle.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Storage: DEPTH entries of {instr, pc}. wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count is tracked separately.
- push = if_valid && if_ready && !flush.
- pop = id_valid && id_ready && !flush.
- if_ready = (count != DEPTH). This is combinational from registered count only. There is no same-cycle pass-through when full, so a push while full is never accepted even if a pop occurs that cycle.
- id_valid = (count != 0). id_instr and id_pc come from the entry at rd_ptr, or NOP_INSTR and 0 when empty.
- Latency: an instruction pushed at edge N appears on id_* after edge N, i.e. one cycle. No bypass from if_* to id_*.
- Per-edge update:
  - push only: write at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count-1.
  - push and pop together (0<count<DEPTH): both pointers advance, count unchanged.
- Empty: pop impossible because id_valid=0, and id_ready is ignored.
- Full: if_ready=0, and if_valid is ignored (fetch is stalled and holds its PC).
- flush=1 at an edge sets wr_ptr=rd_ptr=0 and count=0. Any simultaneous push or pop is discarded. The next cycle shows id_valid=0, id_instr=NOP_INSTR, if_ready=1.
- reset=1: same state as flush. Output values are id_valid=0, id_instr=NOP_INSTR, id_pc=0, if_ready=1, occupancy=0. Reset has priority over flush and the handshakes, including mid-stream.
- Storage contents need no reset; outputs are masked by count==0.
- States are implicit in count: EMPTY (0), PARTIAL, FULL (DEPTH). No separate FSM register.

Optional Feature:
- Macro IFID_PREDECODE_EN.
- When defined:
  - Each entry stores an extra bit ctrl = opcode (instr[6:0]) in {7'b1100011, 7'b1101111, 7'b1100111}, i.e. BRANCH, JAL, JALR. It is computed at push.
  - A new output port id_is_ctrl (1 bit) presents the head's ctrl bit, forced to 0 when empty.
  - This lets decode start hazard/branch handling one cycle earlier.
- When not defined: the port and storage bit do not exist. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - XLEN and NOP_INSTR constants.
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - typedef struct packed {logic [XLEN-1:0] instr; logic [XLEN-1:0] pc;} fetch_pkt_t, which is extended with ctrl under the macro.
- One sub-module, ifid_predecode (pure combinational opcode classifier). It is instantiated only under IFID_PREDECODE_EN.

Test Plan:
- Reset, then idle → id_valid=0, id_instr=32'h00000013, id_pc=0, if_ready=1, occupancy=0.
- Push instr 32'h00500093 at pc 0 with id_ready=1 → next cycle id_valid=1, id_instr=32'h00500093, id_pc=0. The following cycle the queue is empty.
- id_ready=0, push pc 0, 4, 8 → occupancy reaches 2 and if_ready=0. pc 8 is held by fetch. Raise id_ready → order out is 0, 4, 8 with no loss or duplication.
- Full queue, assert flush together with if_valid and id_ready → next cycle occupancy=0, id_valid=0, id_instr=NOP, if_ready=1. The flushed-cycle push is absent.
- Continuous push/pop for 10 cycles (pc 0..36) → occupancy steady at 1, pointer wrap exercised, PCs exit in order.
- With IFID_PREDECODE_EN, push 32'h00000063 (beq) then 32'h00000013 → id_is_ctrl=1 then 0. Empty queue → id_is_ctrl=0.
